ripple_count_sampler: RTL and testbench

Downstream consumer of the 4-bit asynchronous ripple up-counter. Brings the counter's ripple-clocked Q bus into the system clock domain and waits out ripple settling. Publishes each stable value with a one-cycle valid pulse, the modular increment since the previous publish, and a wrap flag. It is the only path by which ripple-counter state reaches synchronous logic.

---
 rtl/rcs_pkg.sv | 23 ++
 rtl/ripple_count_sampler_if.sv | 46 ++++
 rtl/sync_ff_chain.sv | 25 ++
 rtl/ripple_count_sampler.sv | 191 +++++++++++++++++++
 tb/tb_ripple_count_sampler.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/rcs_pkg.sv
// Shared types and defaults for the ripple counter sampler.
// Holds the FSM state encoding, the default geometry, and the sizing
// helper for the settle-filter match counter.
package rcs_pkg;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_TRACK   = 2'd1,
        ST_SETTLE  = 2'd2,
        ST_PUBLISH = 2'd3
    } rcs_state_t;

    localparam int RCS_WIDTH         = 4;
    localparam int RCS_SYNC_STAGES   = 2;
    localparam int RCS_STABLE_CYCLES = 3;
    localparam int RCS_MAX_RESTARTS  = 8;

    // Bits needed to hold a match count of 0..stable_cycles.
    function automatic int match_cnt_width(input int stable_cycles);
        return $clog2(stable_cycles + 1);
    endfunction

endpackage

// File: rtl/ripple_count_sampler_if.sv
// Signal bundle between the ripple counter side and the sampler.
// The unstable_err flag exists only when RCS_UNSTABLE_ERR_EN is defined.
interface ripple_count_sampler_if
    import rcs_pkg::*;
#(
    parameter int WIDTH = RCS_WIDTH
);

    logic [WIDTH-1:0] cnt_async;
    logic             clr;
    logic [WIDTH-1:0] count_out;
    logic             count_vld;
    logic [WIDTH-1:0] delta;
    logic             wrap;
    logic             stable;
`ifdef RCS_UNSTABLE_ERR_EN
    logic             unstable_err;
`endif

    modport master (
        output cnt_async,
        output clr,
        input  count_out,
        input  count_vld,
        input  delta,
        input  wrap,
`ifdef RCS_UNSTABLE_ERR_EN
        input  unstable_err,
`endif
        input  stable
    );

    modport slave (
        input  cnt_async,
        input  clr,
        output count_out,
        output count_vld,
        output delta,
        output wrap,
`ifdef RCS_UNSTABLE_ERR_EN
        output unstable_err,
`endif
        output stable
    );

endinterface

// File: rtl/sync_ff_chain.sv
// Single-bit multi-flop synchronizer with asynchronous active-low reset.
// Only protects against metastability; bus skew is handled downstream.
module sync_ff_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/ripple_count_sampler.sv
// Ripple counter sampler: synchronizes the ripple-clocked Q bus into clk,
// waits for it to settle, and publishes each stable value with the
// modular increment since the last publish and a wrap flag.
// Optional build macro: RCS_UNSTABLE_ERR_EN adds a sticky unstable_err
// flag driven by a saturating count of consecutive settle restarts.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   INIT    | no baseline yet; filtering input toward a first publish
//   TRACK   | synced input equals count_out; stable asserted
//   SETTLE  | input moved; waiting for STABLE_CYCLES identical samples
//   PUBLISH | one cycle; latch candidate into count_out, pulse count_vld
module ripple_count_sampler
    import rcs_pkg::*;
#(
    parameter int WIDTH         = RCS_WIDTH,
    parameter int SYNC_STAGES   = RCS_SYNC_STAGES,
    parameter int STABLE_CYCLES = RCS_STABLE_CYCLES,
    parameter int MAX_RESTARTS  = RCS_MAX_RESTARTS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ripple_count_sampler_if.slave bus
);

    localparam int             MW        = match_cnt_width(STABLE_CYCLES);
    localparam logic [MW-1:0]  MATCH_TC  = MW'(STABLE_CYCLES);
    localparam logic [MW-1:0]  MATCH_ONE = MW'(1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("STABLE_CYCLES must be at least 1");
    end
    if (MAX_RESTARTS < 1) begin : g_bad_restarts
        $error("MAX_RESTARTS must be at least 1");
    end

    logic [WIDTH-1:0] syn;
    logic [WIDTH-1:0] cand,    cand_nxt;
    logic [MW-1:0]    match,   match_nxt;
    logic [WIDTH-1:0] count_q, count_nxt;
    logic [WIDTH-1:0] delta_q, delta_nxt;
    logic             wrap_q,  wrap_nxt;
    logic             vld_q,   vld_nxt;
    logic             base_pend, base_nxt;
    rcs_state_t       state,   state_nxt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_sync
        sync_ff_chain #(
            .STAGES (SYNC_STAGES)
        ) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (bus.cnt_async[i]),
            .q     (syn[i])
        );
    end

    // Next-state and datapath decode; clr overrides every state so a
    // re-baseline request always lands in INIT, even mid-publish.
    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        match_nxt = match;
        count_nxt = count_q;
        delta_nxt = delta_q;
        wrap_nxt  = wrap_q;
        vld_nxt   = 1'b0;
        base_nxt  = base_pend;

        if (bus.clr) begin
            state_nxt = ST_INIT;
            cand_nxt  = '0;
            match_nxt = '0;
            delta_nxt = '0;
            wrap_nxt  = 1'b0;
            base_nxt  = 1'b1;
        end else begin
            unique case (state)
                ST_INIT, ST_SETTLE: begin
                    if (state == ST_SETTLE && syn == count_q) begin
                        state_nxt = ST_TRACK;
                    end else if (syn != cand) begin
                        cand_nxt  = syn;
                        match_nxt = MATCH_ONE;
                    end else if (match == MATCH_TC) begin
                        state_nxt = ST_PUBLISH;
                    end else begin
                        match_nxt = match + MATCH_ONE;
                    end
                end
                ST_TRACK: begin
                    if (syn != count_q) begin
                        cand_nxt  = syn;
                        match_nxt = MATCH_ONE;
                        state_nxt = ST_SETTLE;
                    end
                end
                ST_PUBLISH: begin
                    count_nxt = cand;
                    delta_nxt = base_pend ? '0 : (cand - count_q);
                    wrap_nxt  = base_pend ? 1'b0 : (cand < count_q);
                    vld_nxt   = 1'b1;
                    base_nxt  = 1'b0;
                    state_nxt = ST_TRACK;
                end
                default: begin
                    state_nxt = ST_INIT;
                end
            endcase
        end
    end

    // State and published-value registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            cand      <= '0;
            match     <= '0;
            count_q   <= '0;
            delta_q   <= '0;
            wrap_q    <= 1'b0;
            vld_q     <= 1'b0;
            base_pend <= 1'b1;
        end else begin
            state     <= state_nxt;
            cand      <= cand_nxt;
            match     <= match_nxt;
            count_q   <= count_nxt;
            delta_q   <= delta_nxt;
            wrap_q    <= wrap_nxt;
            vld_q     <= vld_nxt;
            base_pend <= base_nxt;
        end
    end

    assign bus.count_out = count_q;
    assign bus.count_vld = vld_q;
    assign bus.delta     = delta_q;
    assign bus.wrap      = wrap_q;
    assign bus.stable    = (state == ST_TRACK);

`ifdef RCS_UNSTABLE_ERR_EN
    localparam int            RW      = $clog2(MAX_RESTARTS + 1);
    localparam logic [RW-1:0] RST_MAX = RW'(MAX_RESTARTS);

    logic [RW-1:0] rcnt, rcnt_nxt;
    logic          err_q, err_nxt;
    logic          restart;
    logic          rclr;

    // A restart is a candidate replacement while filtering; returning to
    // TRACK, publishing, or clr all break the run of restarts.
    assign restart = !bus.clr && (syn != cand) &&
                     ((state == ST_INIT) || (state == ST_SETTLE && syn != count_q));
    assign rclr    = bus.clr || (state == ST_TRACK) || (state == ST_PUBLISH) ||
                     (state == ST_SETTLE && syn == count_q);

    // Saturating restart count and sticky error flag.
    always_comb begin
        rcnt_nxt = rcnt;
        err_nxt  = err_q;
        if (rclr) begin
            rcnt_nxt = '0;
        end else if (restart && rcnt != RST_MAX) begin
            rcnt_nxt = rcnt + RW'(1);
        end
        if (bus.clr) begin
            err_nxt = 1'b0;
        end else if (restart && rcnt >= RST_MAX - RW'(1)) begin
            err_nxt = 1'b1;
        end
    end

    // Restart counter and error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt  <= '0;
            err_q <= 1'b0;
        end else begin
            rcnt  <= rcnt_nxt;
            err_q <= err_nxt;
        end
    end

    assign bus.unstable_err = err_q;
`endif

endmodule

// File: tb/tb_ripple_count_sampler.sv
// Directed bench for ripple_count_sampler with a publish scoreboard.
module tb_ripple_count_sampler;

    localparam int W   = 4;
    localparam int SS  = 2;
    localparam int SC  = 3;
    localparam int MR  = 8;
    localparam int LAT = SS + SC + 1;

    typedef struct packed {
        logic [W-1:0] out;
        logic [W-1:0] dl;
        logic         wr;
    } exp_t;

    logic clk;
    logic rst_n;

    ripple_count_sampler_if #(.WIDTH(W)) bus ();

    ripple_count_sampler #(
        .WIDTH         (W),
        .SYNC_STAGES   (SS),
        .STABLE_CYCLES (SC),
        .MAX_RESTARTS  (MR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t         sb[$];
    int           checks    = 0;
    int           passes    = 0;
    int           pubs      = 0;
    int           exp_pubs  = 0;
    int           cyc       = 0;
    int           vld_cyc   = 0;
    int           t0        = 0;
    logic [W-1:0] model_out = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Scoreboard: compare every count_vld pulse against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && bus.count_vld === 1'b1) begin
            vld_cyc = cyc;
            pubs++;
            checks++;
            assert (sb.size() != 0) passes++;
            else $error("FAIL sb_unexpected_vld: observed count_vld=1 count_out=%0d expected no publish",
                        bus.count_out);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("pub_count_out", 32'(bus.count_out), 32'(e.out));
                chk("pub_delta",     32'(bus.delta),     32'(e.dl));
                chk("pub_wrap",      32'(bus.wrap),      32'(e.wr));
            end
        end
    end

    task automatic expect_pub(input logic [W-1:0] v, input logic base);
        exp_t e;
        e.out = v;
        e.dl  = base ? '0 : W'(v - model_out);
        e.wr  = base ? 1'b0 : (v < model_out);
        sb.push_back(e);
        model_out = v;
        exp_pubs++;
    endtask

    task automatic wait_pub(input string tag);
        int n;
        n = 0;
        while (pubs < exp_pubs && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk(tag, (pubs >= exp_pubs) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic step(input logic [W-1:0] v, input string tag);
        expect_pub(v, 1'b0);
        bus.cnt_async = v;
        t0 = cyc + 1;
        wait_pub(tag);
        chk({tag, "_lat"}, 32'(vld_cyc - t0), 32'(LAT));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n         = 1'b0;
        bus.cnt_async = 4'b1111;
        bus.clr       = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_count_out", 32'(bus.count_out), 0);
        chk("rst_count_vld", 32'(bus.count_vld), 0);
        chk("rst_delta",     32'(bus.delta),     0);
        chk("rst_wrap",      32'(bus.wrap),      0);
        chk("rst_stable",    32'(bus.stable),    0);
`ifdef RCS_UNSTABLE_ERR_EN
        chk("rst_unstable_err", 32'(bus.unstable_err), 0);
`endif

        // Baseline publish of 15 straight out of reset.
        expect_pub(4'd15, 1'b1);
        rst_n = 1'b1;
        t0 = cyc + 1;
        wait_pub("base15");
        chk("base15_lat", 32'(vld_cyc - t0), 32'(LAT));
        @(negedge clk);
        chk("base15_stable", 32'(bus.stable), 1);

        // Rollover 15 -> 1, then plain step to 7.
        step(4'd1, "wrap15to1");
        step(4'd7, "step1to7");

        // Ripple through intermediate codes, one clk apart, ending on 8.
        expect_pub(4'd8, 1'b0);
        bus.cnt_async = 4'b0110;
        @(negedge clk) bus.cnt_async = 4'b0100;
        @(negedge clk) bus.cnt_async = 4'b0000;
        @(negedge clk) bus.cnt_async = 4'b1000;
        wait_pub("ripple7to8");
        chk("ripple_pub_count", 32'(pubs), 32'(exp_pubs));

        // 8 -> 5 wraps (delta 13).
        step(4'd5, "step8to5");

        // One-cycle glitch back to the published value: nothing published.
        bus.cnt_async = 4'd4;
        @(negedge clk) bus.cnt_async = 4'd5;
        repeat (15) @(negedge clk);
        chk("glitch_no_pub",    32'(pubs),          32'(exp_pubs));
        chk("glitch_count_out", 32'(bus.count_out), 5);
        chk("glitch_stable",    32'(bus.stable),    1);
        chk("hold_delta",       32'(bus.delta),     13);
        chk("hold_wrap",        32'(bus.wrap),      1);

        // clr lands on the PUBLISH cycle of a 5 -> 9 step.
        bus.cnt_async = 4'd9;
        repeat (6) @(negedge clk);
        chk("clr_pub_state_stable", 32'(bus.stable), 0);
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        chk("clr_no_vld",    32'(bus.count_vld), 0);
        chk("clr_count_out", 32'(bus.count_out), 5);
        chk("clr_delta",     32'(bus.delta),     0);
        chk("clr_wrap",      32'(bus.wrap),      0);
        chk("clr_stable",    32'(bus.stable),    0);
        expect_pub(4'd9, 1'b1);
        wait_pub("clr_rebase9");

`ifdef RCS_UNSTABLE_ERR_EN
        // Toggle bit0 every 2 clk while baselining: restarts pile up.
        chk("err_before", 32'(bus.unstable_err), 0);
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.cnt_async = bus.cnt_async ^ 4'b0001;
            repeat (2) @(negedge clk);
            if (i == 5) chk("err_after_6_restarts", 32'(bus.unstable_err), 0);
        end
        chk("err_set", 32'(bus.unstable_err), 1);
        expect_pub(4'd9, 1'b1);
        wait_pub("err_rebase9");
        chk("err_sticky_after_pub", 32'(bus.unstable_err), 1);
        expect_pub(4'd9, 1'b1);
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        chk("err_cleared_by_clr", 32'(bus.unstable_err), 0);
        wait_pub("err_clr_rebase9");
`endif

        // Reset while settling toward 12: immediate return, no partial publish.
        bus.cnt_async = 4'd12;
        repeat (4) @(negedge clk);
        chk("midsettle_state", 32'(bus.stable), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_count_out", 32'(bus.count_out), 0);
        chk("midrst_count_vld", 32'(bus.count_vld), 0);
        chk("midrst_delta",     32'(bus.delta),     0);
        chk("midrst_wrap",      32'(bus.wrap),      0);
        chk("midrst_stable",    32'(bus.stable),    0);
        repeat (2) @(negedge clk);
        chk("midrst_no_pub", 32'(pubs), 32'(exp_pubs));
        model_out = '0;
        expect_pub(4'd12, 1'b1);
        rst_n = 1'b1;
        t0 = cyc + 1;
        wait_pub("midrst_base12");
        chk("midrst_base12_lat", 32'(vld_cyc - t0), 32'(LAT));

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
